// File: rtl/pipe_sub12_pkg.sv
// Shared arithmetic parameters and types for the chunked pipelined adder/subtractor pair.
package pipe_arith_pkg;

  localparam int WIDTH  = 12;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CHUNK-1:0] chunk_t;

endpackage

// File: rtl/pipe_sub12_if.sv
// Operand/result bundle for pipe_sub12; master drives operands, slave returns the difference.
interface pipe_sub12_if;
  import pipe_arith_pkg::*;

  logic  en;
  logic  in_valid;
  word_t a;
  word_t b;
  logic  out_valid;
  word_t d;
  logic  borrow_out;

  modport master (
    output en, in_valid, a, b,
    input  out_valid, d, borrow_out
  );

  modport slave (
    input  en, in_valid, a, b,
    output out_valid, d, borrow_out
  );

endinterface

// File: rtl/pipe_sub12_sub_chunk.sv
// Combinational ripple-borrow subtractor over one chunk, built from full-subtractor cells.
module sub_chunk
  import pipe_arith_pkg::*;
(
  input  chunk_t x,
  input  chunk_t y,
  input  logic   bi,
  output chunk_t diff,
  output logic   bo
);

  logic [CHUNK:0] br;

  assign br[0] = bi;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign diff[i]  = x[i] ^ y[i] ^ br[i];
    assign br[i+1]  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
  end

  assign bo = br[CHUNK];

endmodule

// File: rtl/pipe_sub12.sv
// Pipelined unsigned subtractor d = a - b; one chunk resolved per stage, borrow carried in registers.
module pipe_sub12 #(
  parameter int WIDTH = pipe_arith_pkg::WIDTH,
  parameter int CHUNK = pipe_arith_pkg::CHUNK
) (
  input logic         clk,
  input logic         reset,
  pipe_sub12_if.slave bus
);
  import pipe_arith_pkg::*;

  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("pipe_sub12: WIDTH must be a multiple of CHUNK");
  end

  logic [WIDTH-1:0] opa   [STAGES];
  logic [WIDTH-1:0] opb   [STAGES];
  logic             vld   [STAGES];
  logic [WIDTH-1:0] part  [1:STAGES-1];
  logic             bor   [1:STAGES-1];
  logic [CHUNK-1:0] cdiff [STAGES];
  logic             cbo   [STAGES];
  logic             cbi   [STAGES];

  // Chunk s reads the operands held in stage register s; its borrow-in is the
  // borrow registered alongside them, so each operation only sees its own borrow.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign cbi[s] = 1'b0;
    end else begin : g_rest
      assign cbi[s] = bor[s];
    end

    sub_chunk u_sub (
      .x    (opa[s][CHUNK*s +: CHUNK]),
      .y    (opb[s][CHUNK*s +: CHUNK]),
      .bi   (cbi[s]),
      .diff (cdiff[s]),
      .bo   (cbo[s])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        opa[s] <= '0;
        opb[s] <= '0;
        vld[s] <= 1'b0;
      end
      for (int s = 1; s < STAGES; s++) begin
        part[s] <= '0;
        bor[s]  <= 1'b0;
      end
      bus.out_valid  <= 1'b0;
      bus.d          <= '0;
      bus.borrow_out <= 1'b0;
    end else if (bus.en) begin
      opa[0] <= bus.a;
      opb[0] <= bus.b;
      vld[0] <= bus.in_valid;
      for (int s = 1; s < STAGES; s++) begin
        opa[s] <= opa[s-1];
        opb[s] <= opb[s-1];
        vld[s] <= vld[s-1];
        bor[s] <= cbo[s-1];
      end
      part[1] <= WIDTH'(cdiff[0]);
      for (int s = 2; s < STAGES; s++) begin
        part[s]                       <= part[s-1];
        part[s][CHUNK*(s-1) +: CHUNK] <= cdiff[s-1];
      end
      // The output register doubles as the last compute stage; bubbles never overwrite d.
      if (vld[STAGES-1]) begin
        bus.d          <= {cdiff[STAGES-1], part[STAGES-1][WIDTH-CHUNK-1:0]};
        bus.borrow_out <= cbo[STAGES-1];
        bus.out_valid  <= 1'b1;
      end else begin
        bus.out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_sub12.sv
// Self-checking bench for pipe_sub12: directed cases plus a randomized run against a delay-line model.
module tb_pipe_sub12;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   issued;
  string phase;

  pipe_sub12_if bus ();

  pipe_sub12 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each issued op becomes (a-b mod 4096, a<b) and emerges after three enabled edges.
  logic        mv [3];
  logic [11:0] md [3];
  logic        mb [3];
  logic        out_v;
  logic [11:0] out_d;
  logic        out_b;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s/%s: got %0h, expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic [11:0] xa, input logic [11:0] xb);
    @(negedge clk);
    reset        = r;
    bus.en       = e;
    bus.in_valid = v;
    bus.a        = xa;
    bus.b        = xb;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        mv[i] = 1'b0;
        md[i] = '0;
        mb[i] = 1'b0;
      end
      out_v = 1'b0;
      out_d = '0;
      out_b = 1'b0;
    end else if (e) begin
      if (mv[2]) begin
        out_v = 1'b1;
        out_d = md[2];
        out_b = mb[2];
      end else begin
        out_v = 1'b0;
      end
      for (int i = 2; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
        mb[i] = mb[i-1];
      end
      mv[0] = v;
      md[0] = xa - xb;
      mb[0] = (xa < xb);
      if (v) issued++;
    end
    #1;
    checkOutput("out_valid", bus.out_valid, out_v);
    checkOutput("d", bus.d, out_d);
    checkOutput("borrow_out", bus.borrow_out, out_b);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 12'($urandom), 12'($urandom));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    issued       = 0;
    phase        = "reset";
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    applyStimulus(1'b1, 1'b1, 1'b1, 12'hABC, 12'h123);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 12'h000);

    phase = "single";
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h800, 12'h001);
    idle();
    idle();
    idle();
    checkOutput("first_valid", bus.out_valid, 1);
    checkOutput("first_d", bus.d, 12'h7FF);
    checkOutput("first_borrow", bus.borrow_out, 0);
    idle();
    checkOutput("single_pulse", bus.out_valid, 0);

    phase = "b2b";
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h000, 12'h001);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h123, 12'h123);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'hF0F, 12'h0F1);
    idle();
    checkOutput("wrap_d", bus.d, 12'hFFF);
    checkOutput("wrap_borrow", bus.borrow_out, 1);
    idle();
    checkOutput("equal_valid", bus.out_valid, 1);
    checkOutput("equal_d", bus.d, 12'h000);
    checkOutput("equal_borrow", bus.borrow_out, 0);
    idle();
    checkOutput("mixed_d", bus.d, 12'hE1E);
    checkOutput("mixed_borrow", bus.borrow_out, 0);
    idle();

    phase = "stall";
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h100, 12'h0FF);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h333, 12'h111);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h444, 12'h222);
    idle();
    idle();
    checkOutput("not_yet", bus.out_valid, 0);
    idle();
    checkOutput("stall_valid", bus.out_valid, 1);
    checkOutput("stall_d", bus.d, 12'h001);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
    checkOutput("held_d", bus.d, 12'h001);
    idle();
    checkOutput("no_extra", bus.out_valid, 0);

    phase = "flush";
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h555, 12'hAAA);
    idle();
    applyStimulus(1'b1, 1'b1, 1'b1, 12'h777, 12'h001);
    checkOutput("flushed_d", bus.d, 12'h000);
    checkOutput("flushed_borrow", bus.borrow_out, 0);
    for (int i = 0; i < 5; i++) idle();

    phase  = "random";
    issued = 0;
    for (int cyc = 0; cyc < 40000 && issued < 10000; cyc++) begin
      logic [11:0] ra;
      logic [11:0] rb;
      ra = 12'($urandom);
      rb = 12'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) ra = 12'h000;
      applyStimulus(1'b0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, ra, rb);
    end
    checkOutput("ops_issued", issued, 10000);
    for (int i = 0; i < 6; i++) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/pipe_sub12.md
Name: pipe_sub12

Overview:
- 12-bit pipelined unsigned subtractor, d = a - b. Operands are split into 4-bit chunks; the borrow ripples chunk-to-chunk through registered stages.
- Companion and inverse of the team's 3-stage pipelined 12-bit chunked adder. It has the same chunk structure and the same latency, so the two can be lane-matched in a datapath.
- Adds valid tracking, a global stall and a synchronous reset, none of which the adder has.

Parameters:
- WIDTH, 12, operand and result width.
- CHUNK, 4, bits resolved per pipeline stage. WIDTH must be a multiple of CHUNK.
- STAGES, WIDTH/CHUNK (=3), number of compute stages. This is derived; do not override it.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  pipeline advance enable. When 0, every register holds.
- in_valid  input  1  a/b carry a valid operation this cycle.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  d/borrow_out hold a new result this cycle.
- d  output  WIDTH  difference, (a - b) mod 2^WIDTH.
- borrow_out  output  1  set to 1 iff a < b (unsigned).

Behaviour:
- Reset (sampled at a rising edge while reset=1):
  - Clears out_valid, d, borrow_out, all stage valid bits, all operand/partial-difference registers and all inter-stage borrow registers to 0.
  - reset has priority over en.
  - Any operations in flight are discarded: no out_valid pulses for them after reset is released.
- Stage 0 (input register): at an edge with en=1, captures a, b and in_valid.
- Stage s (s = 1..STAGES):
  - Computes chunk s-1 of the difference, bits [CHUNK*s-1 : CHUNK*(s-1)], combinationally with one sub_chunk instance.
  - Borrow-in is 0 for s=1; otherwise it is the registered borrow-out of stage s-1.
  - At an edge with en=1, registers: the chunk result, which is appended to the already-resolved lower chunks; that stage's borrow-out; the still-unused upper operand bits; and the valid bit.
- Latency: an operation sampled at edge k (en=1 at k and at every following edge) appears on d/out_valid after edge k+STAGES (k+3 at default).
  - Each edge with en=0 adds one cycle.
- Throughput: one operation per enabled cycle. Back-to-back operations must not interfere; the borrow of operation n must never reach operation n+1.
- Output register:
  - Loads d, borrow_out and out_valid=1 only when the final-stage valid bit is 1 and en=1.
  - When the final-stage valid bit is 0 and en=1: out_valid goes to 0, and d and borrow_out hold their last value.
  - When en=0: out_valid, d and borrow_out all hold. out_valid can therefore stay high for several cycles during a stall; this represents one result, not several.
- Bubbles (in_valid=0):
  - Data registers may load don't-care values.
  - Valid bits propagate 0, and the output never updates from a bubble.
- Arithmetic:
  - Chunk: {bo, diff} = x - y - bi, computed in CHUNK+1 bits. bo is the MSB of that result, i.e. 1 when x < y + bi.
  - borrow_out is the borrow of the last chunk.
  - Wrap-around examples: 0x000 - 0x001 = 0xFFF with borrow 1; a == b gives 0x000 with borrow 0.
- No X on any output after the first reset, regardless of the values of a and b.

Decomposition:
- Package pipe_arith_pkg holds: localparams WIDTH=12, CHUNK=4, STAGES; and typedefs word_t (WIDTH bits) and chunk_t (CHUNK bits). The adder may reuse this package.
- One sub-module, sub_chunk:
  - Purely combinational CHUNK-bit ripple-borrow subtractor.
  - Ports x, y, bi, diff, bo.
  - Built from per-bit full-subtractor cells, mirroring the adder's full-adder cells.
  - Instantiated STAGES times from a generate loop.

Test Plan:
- Reset, then a=0x800, b=0x001, in_valid=1 for one cycle with en=1 → three edges later, out_valid=1 for exactly one cycle, d=0x7FF, borrow_out=0.
- a=0x000, b=0x001, then a=0x123, b=0x123, then a=0xF0F, b=0x0F1, on three consecutive cycles → out_valid high for three consecutive cycles with:
  - d=0xFFF, borrow 1;
  - d=0x000, borrow 0;
  - d=0xE1E, borrow 0.
  (Checks cross-chunk borrow isolation between back-to-back operations.)
- a=0x100, b=0x0FF issued, then en=0 for 2 cycles mid-flight → the result d=0x001, borrow 0 appears 5 cycles after issue. d holds steady and no extra operation emerges.
- Issue a=0x555, b=0xAAA, then assert reset for 1 cycle one edge later → no out_valid afterwards; d=0x000, borrow_out=0 the cycle after reset.
- Random-operand scoreboard, 10k operations with random in_valid and en (about 70% high each) → every out_valid result matches (a-b) mod 4096 and a<b, in issue order.
